// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
//
// Shares one DATA_W-bit ALU between NUM_REQ requesters. A round-robin arbiter
// picks one valid request in IDLE, registers its operands (which drive the ALU
// pins directly), captures the ALU result one cycle later and returns it with
// the winner's index over a valid/ready response channel.
//
// Build option: define ALU_ARB_OPCHECK_EN to screen opcodes. Illegal opcodes
// are then replaced by PASS on the ALU pins, and the response carries
// rsp_err=1, rsp_result=0, rsp_zero=1.
//
// Ports:
//   clk, rst              clock (rising edge), synchronous active-high reset
//   req_valid/req_ready   per-requester handshake, req_ready one-hot or zero
//   req_a/req_b/req_op    packed operands/opcode, requester i at slice i
//   alu_in1/alu_in2/alu_op  registered drive to the shared ALU
//   alu_result/alu_zero   ALU outputs, captured in EXEC
//   rsp_valid/rsp_ready   response handshake
//   rsp_id/rsp_result/rsp_zero  response payload (rsp_err with the option)
// -----------------------------------------------------------------------------
module alu_share_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 64,
    parameter int ID_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic [NUM_REQ*4-1:0]      req_op,
    output logic [DATA_W-1:0]         alu_in1,
    output logic [DATA_W-1:0]         alu_in2,
    output logic [3:0]                alu_op,
    input  logic [DATA_W-1:0]         alu_result,
    input  logic                      alu_zero,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_result,
    output logic                      rsp_zero
`ifdef ALU_ARB_OPCHECK_EN
    ,
    output logic                      rsp_err
`endif
);

    localparam logic [3:0] OP_PASS = 4'b0111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]     win_q, win_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [3:0]          op_q, op_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0]   rsp_result_q, rsp_result_d;
    logic                rsp_zero_q, rsp_zero_d;
`ifdef ALU_ARB_OPCHECK_EN
    logic                err_q, err_d;
    logic                rsp_err_q, rsp_err_d;
`endif

    logic                grant_found_s;
    logic [ID_W-1:0]     grant_idx_s;
    logic                hit_s;
    logic [DATA_W-1:0]   sel_a_s;
    logic [DATA_W-1:0]   sel_b_s;
    logic [3:0]          sel_op_s;
    logic [NUM_REQ-1:0]  req_ready_s;

`ifdef ALU_ARB_OPCHECK_EN
    function automatic logic op_is_legal(input logic [3:0] op);
        logic legal;
        case (op)
            4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100: legal = 1'b1;
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction
`endif

    // Round-robin search: scan offsets 0..NUM_REQ-1 from rr_ptr, first valid wins.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        hit_s         = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                hit_s = (j == ((int'(rr_ptr_q) + k) % NUM_REQ)) && req_valid[j] && !grant_found_s;
                grant_idx_s   = hit_s ? ID_W'(j) : grant_idx_s;
                grant_found_s = grant_found_s | hit_s;
            end
        end
    end

    // Operand mux for the winner and the one-hot ready (only meaningful in IDLE).
    always_comb begin
        sel_a_s     = '0;
        sel_b_s     = '0;
        sel_op_s    = 4'b0000;
        req_ready_s = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (grant_found_s && (grant_idx_s == ID_W'(j))) begin
                sel_a_s        = req_a[j*DATA_W +: DATA_W];
                sel_b_s        = req_b[j*DATA_W +: DATA_W];
                sel_op_s       = req_op[j*4 +: 4];
                req_ready_s[j] = (state_q == ST_IDLE);
            end else begin
                req_ready_s[j] = 1'b0;
            end
        end
    end

    // Next-state and datapath register updates for the IDLE/EXEC/RESP sequence.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        win_d        = win_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
`ifdef ALU_ARB_OPCHECK_EN
        err_d        = err_q;
        rsp_err_d    = rsp_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (grant_found_s) begin
                    a_d   = sel_a_s;
                    b_d   = sel_b_s;
                    win_d = grant_idx_s;
`ifdef ALU_ARB_OPCHECK_EN
                    // Illegal codes never reach the ALU; PASS keeps it well-defined.
                    op_d  = op_is_legal(sel_op_s) ? sel_op_s : OP_PASS;
                    err_d = !op_is_legal(sel_op_s);
`else
                    op_d  = sel_op_s;
`endif
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                rsp_valid_d = 1'b1;
                rsp_id_d    = win_q;
`ifdef ALU_ARB_OPCHECK_EN
                rsp_result_d = err_q ? '0 : alu_result;
                rsp_zero_d   = err_q ? 1'b1 : alu_zero;
                rsp_err_d    = err_q;
`else
                rsp_result_d = alu_result;
                rsp_zero_d   = alu_zero;
`endif
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rr_ptr_d    = (win_q == ID_W'(NUM_REQ - 1)) ? '0 : win_q + ID_W'(1);
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= '0;
            win_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= OP_PASS;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
`ifdef ALU_ARB_OPCHECK_EN
            err_q        <= 1'b0;
            rsp_err_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            win_q        <= win_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
`ifdef ALU_ARB_OPCHECK_EN
            err_q        <= err_d;
            rsp_err_q    <= rsp_err_d;
`endif
        end
    end

    assign req_ready  = req_ready_s;
    assign alu_in1    = a_q;
    assign alu_in2    = b_q;
    assign alu_op     = op_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;
`ifdef ALU_ARB_OPCHECK_EN
    assign rsp_err    = rsp_err_q;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

    localparam int NUM_REQ = 2;
    localparam int DATA_W  = 64;
    localparam int ID_W    = 2;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_PASS = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1100;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic [NUM_REQ*4-1:0]      req_op;
    logic [DATA_W-1:0]         alu_in1;
    logic [DATA_W-1:0]         alu_in2;
    logic [3:0]                alu_op;
    logic [DATA_W-1:0]         alu_result;
    logic                      alu_zero;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [ID_W-1:0]           rsp_id;
    logic [DATA_W-1:0]         rsp_result;
    logic                      rsp_zero;
`ifdef ALU_ARB_OPCHECK_EN
    logic                      rsp_err;
`endif

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] result;
        logic              zero;
        logic              err;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_exp;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .alu_in1    (alu_in1),
        .alu_in2    (alu_in2),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero)
`ifdef ALU_ARB_OPCHECK_EN
        ,
        .rsp_err    (rsp_err)
`endif
    );

    // Behavioural stand-in for the shared ALU.
    function automatic logic [DATA_W-1:0] alu_model(input logic [DATA_W-1:0] a,
                                                    input logic [DATA_W-1:0] b,
                                                    input logic [3:0] op);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0111: return a;
            4'b1100: return ~(a | b);
            default: return 64'd0;
        endcase
    endfunction

    assign alu_result = alu_model(alu_in1, alu_in2, alu_op);
    assign alu_zero   = (alu_result == 64'd0);

    // Scoreboard: every completed response handshake is matched against the queue.
    always @(negedge clk) begin
        if (rst === 1'b0 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: got id=%0d result=%h, required no response", rsp_id, rsp_result);
            end else begin
                mon_exp = sb_q.pop_front();
`ifdef ALU_ARB_OPCHECK_EN
                if (rsp_id !== mon_exp.id || rsp_result !== mon_exp.result || rsp_zero !== mon_exp.zero || rsp_err !== mon_exp.err) begin
                    errors++;
                    $display("FAIL rsp_data: got id=%0d result=%h zero=%0b err=%0b, required id=%0d result=%h zero=%0b err=%0b",
                             rsp_id, rsp_result, rsp_zero, rsp_err, mon_exp.id, mon_exp.result, mon_exp.zero, mon_exp.err);
                end
`else
                if (rsp_id !== mon_exp.id || rsp_result !== mon_exp.result || rsp_zero !== mon_exp.zero) begin
                    errors++;
                    $display("FAIL rsp_data: got id=%0d result=%h zero=%0b, required id=%0d result=%h zero=%0b",
                             rsp_id, rsp_result, rsp_zero, mon_exp.id, mon_exp.result, mon_exp.zero);
                end
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [ID_W-1:0] id, input logic [DATA_W-1:0] result,
                            input logic zero, input logic err);
        exp_t e;
        e.id = id; e.result = result; e.zero = zero; e.err = err;
        sb_q.push_back(e);
    endtask

    task automatic set_req(input logic r, input logic [DATA_W-1:0] a,
                           input logic [DATA_W-1:0] b, input logic [3:0] op);
        if (r == 1'b0) begin
            req_a[63:0] = a; req_b[63:0] = b; req_op[3:0] = op; req_valid[0] = 1'b1;
        end else begin
            req_a[127:64] = a; req_b[127:64] = b; req_op[7:4] = op; req_valid[1] = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 2'b00; rsp_ready = 1'b1;
        req_a = '0; req_b = '0; req_op = '0;
        tick(); tick();
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b, required 00", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b, required 0", rsp_valid); end
        checks++; if (rsp_id !== 2'd0 || rsp_result !== 64'd0 || rsp_zero !== 1'b0) begin
            errors++; $display("FAIL reset_rsp_payload: got id=%0d result=%h zero=%b, required 0/0/0", rsp_id, rsp_result, rsp_zero); end
        checks++; if (alu_in1 !== 64'd0 || alu_in2 !== 64'd0) begin
            errors++; $display("FAIL reset_alu_in: got %h %h, required 0 0", alu_in1, alu_in2); end
        checks++; if (alu_op !== OP_PASS) begin errors++; $display("FAIL reset_alu_op: got %b, required 0111", alu_op); end
`ifdef ALU_ARB_OPCHECK_EN
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b, required 0", rsp_err); end
`endif
        rst = 1'b0;
    endtask

    task automatic test_single_add();
        tick();
        set_req(1'b0, 64'd5, 64'd7, OP_ADD); #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL add_req_ready: got %b, required 01", req_ready); end
        push_exp(2'd0, 64'd12, 1'b0, 1'b0);
        tick(); req_valid = 2'b00;
        checks++; if (alu_in1 !== 64'd5 || alu_in2 !== 64'd7 || alu_op !== OP_ADD) begin
            errors++; $display("FAIL add_alu_drive: got %h %h %b, required 5 7 0010", alu_in1, alu_in2, alu_op); end
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 2'b00) begin
            errors++; $display("FAIL add_exec_state: got rsp_valid=%b req_ready=%b, required 0 00", rsp_valid, req_ready); end
        tick();
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL add_latency: got rsp_valid=%b, required 1", rsp_valid); end
        tick();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL add_rsp_drop: got rsp_valid=%b, required 0", rsp_valid); end
    endtask

    task automatic test_sub_zero();
        set_req(1'b1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, OP_SUB); #1;
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL sub_req_ready: got %b, required 10", req_ready); end
        push_exp(2'd1, 64'd0, 1'b1, 1'b0);
        tick(); req_valid = 2'b00;
        tick(); tick();
    endtask

    task automatic test_round_robin();
        logic [3:0] order;
        int gcount;
        int cyc;
        int last_cyc;
        order = 4'b0000; gcount = 0; cyc = 0; last_cyc = 0;
        set_req(1'b0, 64'hF0, 64'h3C, OP_AND);
        set_req(1'b1, 64'h0, 64'h0, OP_NOR); #1;
        while (gcount < 4 && cyc < 40) begin
            if (req_ready != 2'b00) begin
                order = {order[2:0], req_ready[1]};
                push_exp(req_ready[1] ? 2'd1 : 2'd0,
                         req_ready[1] ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h30, 1'b0, 1'b0);
                if (gcount > 0) begin
                    checks++;
                    if (cyc - last_cyc != 3) begin
                        errors++; $display("FAIL rr_issue_interval: got %0d cycles, required 3", cyc - last_cyc);
                    end
                end
                last_cyc = cyc;
                gcount++;
            end
            tick(); cyc++;
        end
        req_valid = 2'b00;
        checks++; if (gcount != 4) begin errors++; $display("FAIL rr_timeout: got %0d grants, required 4", gcount); end
        checks++; if (order !== 4'b0101) begin errors++; $display("FAIL rr_order: got %b, required 0101", order); end
        tick(); tick();
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        set_req(1'b0, 64'd1, 64'd2, OP_ADD); #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL bp_req_ready: got %b, required 01", req_ready); end
        push_exp(2'd0, 64'd3, 1'b0, 1'b0);
        tick(); req_valid[0] = 1'b0;
        set_req(1'b1, 64'h10, 64'h01, OP_OR); #1;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL bp_exec_ready: got %b, required 00", req_ready); end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_result !== 64'd3 || rsp_zero !== 1'b0 || req_ready !== 2'b00) begin
                errors++;
                $display("FAIL bp_hold: cycle %0d got valid=%b id=%0d result=%h zero=%b ready=%b, required 1 0 3 0 00",
                         i, rsp_valid, rsp_id, rsp_result, rsp_zero, req_ready);
            end
        end
        rsp_ready = 1'b1;
        tick();
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL bp_pending_grant: got %b, required 10", req_ready); end
        push_exp(2'd1, 64'h11, 1'b0, 1'b0);
        tick(); req_valid = 2'b00;
        tick(); tick();
    endtask

    task automatic test_reset_mid_op();
        set_req(1'b0, 64'd9, 64'd1, OP_SUB); #1;
        push_exp(2'd0, 64'd8, 1'b0, 1'b0);
        tick(); req_valid = 2'b00;
        tick(); tick();
        set_req(1'b1, 64'd3, 64'd3, OP_ADD); #1;
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL rmo_req_ready: got %b, required 10", req_ready); end
        tick(); req_valid = 2'b00; rst = 1'b1;
        tick(); rst = 1'b0;
        checks++; if (rsp_valid !== 1'b0 || alu_op !== OP_PASS || alu_in1 !== 64'd0) begin
            errors++; $display("FAIL rmo_cleared: got valid=%b op=%b in1=%h, required 0 0111 0", rsp_valid, alu_op, alu_in1); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rmo_no_rsp: cycle %0d got rsp_valid=%b, required 0", i, rsp_valid); end
        end
        set_req(1'b0, 64'hFF, 64'h0F, OP_AND);
        set_req(1'b1, 64'd1, 64'd1, OP_ADD); #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rmo_rr_ptr: got %b, required 01", req_ready); end
        push_exp(2'd0, 64'h0F, 1'b0, 1'b0);
        tick(); req_valid = 2'b00;
        tick(); tick();
    endtask

`ifdef ALU_ARB_OPCHECK_EN
    task automatic test_opcheck();
        set_req(1'b0, 64'd7, 64'd9, 4'b0101); #1;
        push_exp(2'd0, 64'd0, 1'b1, 1'b1);
        tick(); req_valid = 2'b00;
        checks++; if (alu_op !== OP_PASS) begin errors++; $display("FAIL opchk_alu_op: got %b, required 0111", alu_op); end
        tick(); tick();
        set_req(1'b0, 64'd1, 64'd2, OP_OR); #1;
        push_exp(2'd0, 64'd3, 1'b0, 1'b0);
        tick(); req_valid = 2'b00;
        tick(); tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single_add();
        test_sub_zero();
        test_round_robin();
        test_backpressure();
        test_reset_mid_op();
`ifdef ALU_ARB_OPCHECK_EN
        test_opcheck();
`endif
        tick(); tick();
        checks++;
        if (sb_q.size() != 0) begin
            errors++; $display("FAIL sb_drain: got %0d outstanding responses, required 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
